oflow_score_board: RTL

- Per-frame storage of PE matching results (candidate pairs) in a NUM_ROWS x PE_NUM array; sits directly upstream of the conflict-resolve FSM.
- Fills from the PEs, launches conflict resolution, and serves combinational reads and pointer (primary/fallback) updates to the resolver.
- Streams the resolved per-entry ID/score downstream with a valid/ready handshake.

---
 rtl/oflow_score_board_if.sv | 57 +++++
 rtl/oflow_score_board.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_score_board_if.sv
// Handshake/bus bundle between the score board (slave) and its PE, resolver and drain peers (master).
// Drain uses valid/ready: a beat transfers on a cycle where out_valid && out_ready; while out_valid is high
// and out_ready is low the source holds out_row/out_pe/out_id/out_score unchanged.
interface oflow_score_board_if #(
  parameter int ROW_LEN   = 4,
  parameter int PE_LEN    = 3,
  parameter int SCORE_LEN = 11,
  parameter int ID_LEN    = 12
);
  logic                 frame_start;
  logic                 frame_end;
  logic                 pe_wr_valid;
  logic [PE_LEN-1:0]    pe_wr_idx;
  logic [SCORE_LEN-1:0] pe_score_a;
  logic [ID_LEN-1:0]    pe_id_a;
  logic [SCORE_LEN-1:0] pe_score_b;
  logic [ID_LEN-1:0]    pe_id_b;
  logic                 pe_row_done;
  logic                 start_cr;
  logic                 done_cr;
  logic                 conflict_counter_th;
  logic [ROW_LEN-1:0]   row_sel;
  logic [PE_LEN-1:0]    pe_sel;
  logic                 csb;
  logic [SCORE_LEN-1:0] score_to_cr;
  logic [ID_LEN-1:0]    id_to_cr;
  logic [ROW_LEN-1:0]   row_to_change;
  logic [PE_LEN-1:0]    pe_to_change;
  logic                 write_to_pointer;
  logic                 data_to_score_board;
  logic                 out_valid;
  logic                 out_ready;
  logic [ROW_LEN-1:0]   out_row;
  logic [PE_LEN-1:0]    out_pe;
  logic [ID_LEN-1:0]    out_id;
  logic [SCORE_LEN-1:0] out_score;
  logic                 frame_done;
  logic                 conflict_err;

  modport slave (
    input  frame_start, frame_end, pe_wr_valid, pe_wr_idx, pe_score_a, pe_id_a,
           pe_score_b, pe_id_b, pe_row_done, done_cr, conflict_counter_th,
           row_sel, pe_sel, csb, row_to_change, pe_to_change, write_to_pointer,
           data_to_score_board, out_ready,
    output start_cr, score_to_cr, id_to_cr, out_valid, out_row, out_pe, out_id,
           out_score, frame_done, conflict_err
  );

  modport master (
    output frame_start, frame_end, pe_wr_valid, pe_wr_idx, pe_score_a, pe_id_a,
           pe_score_b, pe_id_b, pe_row_done, done_cr, conflict_counter_th,
           row_sel, pe_sel, csb, row_to_change, pe_to_change, write_to_pointer,
           data_to_score_board, out_ready,
    input  start_cr, score_to_cr, id_to_cr, out_valid, out_row, out_pe, out_id,
           out_score, frame_done, conflict_err
  );
endinterface

// File: rtl/oflow_score_board.sv
// Per-frame candidate-pair store: filled by the PEs, read/pointer-updated by the resolver, then drained.
// Optional macro OFLOW_SB_SKIP_EMPTY_EN: the drain skips entries whose selected ID is 0.
module oflow_score_board #(
  parameter int NUM_ROWS  = 8,
  parameter int ROW_LEN   = 4,
  parameter int PE_NUM    = 4,
  parameter int PE_LEN    = 3,
  parameter int SCORE_LEN = 11,
  parameter int ID_LEN    = 12
) (
  input  logic               clk,
  input  logic               reset_N,
  oflow_score_board_if.slave sb,
  output logic [1:0]         dbg_state_o
);
  localparam int TOTAL = NUM_ROWS * PE_NUM;
  localparam int IDX_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESOLVE, S_DRAIN} state_e;
  state_e state_q, state_d;

  // Entries are stored flat, index = row * PE_NUM + pe.
  logic [SCORE_LEN-1:0] score_a_q [TOTAL];
  logic [SCORE_LEN-1:0] score_b_q [TOTAL];
  logic [ID_LEN-1:0]    id_a_q    [TOTAL];
  logic [ID_LEN-1:0]    id_b_q    [TOTAL];
  logic [TOTAL-1:0]     ptr_q;

  logic [ROW_LEN-1:0]   wr_row_q, wr_row_d;
  logic [IDX_W-1:0]     drain_idx_q, next_idx;
  logic                 start_cr_q, frame_done_q, conflict_err_q, out_valid_q;
  logic [ROW_LEN-1:0]   out_row_q;
  logic [PE_LEN-1:0]    out_pe_q;
  logic [ID_LEN-1:0]    out_id_q;
  logic [SCORE_LEN-1:0] out_score_q;

  logic clear_frame, fill_wr_en, row_adv, ptr_wr_en, launch_cr;
  logic enter_drain, drain_step, drain_load, drain_finish;
  logic wr_in_range, rd_en, ptr_in_range;
  logic [IDX_W-1:0]     wr_addr, rd_addr, ptr_addr;
  logic [SCORE_LEN-1:0] rd_score, ld_score;
  logic [ID_LEN-1:0]    rd_id, ld_id;
  logic [ROW_LEN-1:0]   ld_row;
  logic [PE_LEN-1:0]    ld_pe;

  always_comb begin
    wr_addr      = IDX_W'(wr_row_q) * IDX_W'(PE_NUM) + IDX_W'(sb.pe_wr_idx);
    rd_addr      = IDX_W'(sb.row_sel) * IDX_W'(PE_NUM) + IDX_W'(sb.pe_sel);
    ptr_addr     = IDX_W'(sb.row_to_change) * IDX_W'(PE_NUM) + IDX_W'(sb.pe_to_change);
    wr_in_range  = (wr_row_q < ROW_LEN'(NUM_ROWS)) && (sb.pe_wr_idx < PE_LEN'(PE_NUM));
    rd_en        = !sb.csb && (sb.row_sel < ROW_LEN'(NUM_ROWS)) && (sb.pe_sel < PE_LEN'(PE_NUM));
    ptr_in_range = (sb.row_to_change < ROW_LEN'(NUM_ROWS)) && (sb.pe_to_change < PE_LEN'(PE_NUM));
  end

  // Resolver read port: combinational, returns the candidate selected by the current pointer.
  always_comb begin
    rd_score = '0;
    rd_id    = '0;
    for (int k = 0; k < TOTAL; k++) begin
      if (rd_en && rd_addr == IDX_W'(k)) begin
        rd_score = ptr_q[k] ? score_b_q[k] : score_a_q[k];
        rd_id    = ptr_q[k] ? id_b_q[k]    : id_a_q[k];
      end
    end
  end

  // Next entry to put on the drain port, at or after drain_idx_q; TOTAL means nothing left.
  always_comb begin
`ifdef OFLOW_SB_SKIP_EMPTY_EN
    next_idx = IDX_W'(TOTAL);
    for (int k = TOTAL - 1; k >= 0; k--) begin
      if (IDX_W'(k) >= drain_idx_q && (ptr_q[k] ? id_b_q[k] : id_a_q[k]) != '0)
        next_idx = IDX_W'(k);
    end
`else
    next_idx = drain_idx_q;
`endif
  end

  always_comb begin
    ld_score = '0;
    ld_id    = '0;
    for (int k = 0; k < TOTAL; k++) begin
      if (next_idx == IDX_W'(k)) begin
        ld_score = ptr_q[k] ? score_b_q[k] : score_a_q[k];
        ld_id    = ptr_q[k] ? id_b_q[k]    : id_a_q[k];
      end
    end
    ld_row = ROW_LEN'(next_idx / IDX_W'(PE_NUM));
    ld_pe  = PE_LEN'(next_idx % IDX_W'(PE_NUM));
  end

  always_comb begin
    wr_row_d = wr_row_q;
    if (clear_frame)  wr_row_d = '0;
    else if (row_adv) wr_row_d = wr_row_q + ROW_LEN'(1);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sb.frame_start) state_d = S_FILL;
      S_FILL:    if (sb.frame_end || wr_row_d == ROW_LEN'(NUM_ROWS)) state_d = S_RESOLVE;
      S_RESOLVE: if (sb.done_cr) state_d = S_DRAIN;
      S_DRAIN:   if (drain_finish) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: per-state decode
  always_comb begin
    clear_frame = 1'b0;
    fill_wr_en  = 1'b0;
    row_adv     = 1'b0;
    ptr_wr_en   = 1'b0;
    enter_drain = 1'b0;
    drain_step  = 1'b0;
    case (state_q)
      S_IDLE:    clear_frame = sb.frame_start;
      S_FILL: begin
        fill_wr_en = sb.pe_wr_valid && wr_in_range;
        row_adv    = sb.pe_row_done && (wr_row_q != ROW_LEN'(NUM_ROWS));
      end
      S_RESOLVE: begin
        ptr_wr_en   = sb.write_to_pointer && ptr_in_range;
        enter_drain = sb.done_cr;
      end
      S_DRAIN:   drain_step = !out_valid_q || sb.out_ready;
      default:   ;
    endcase
    launch_cr    = (state_q == S_FILL) && (state_d == S_RESOLVE);
    drain_load   = drain_step && (next_idx < IDX_W'(TOTAL));
    drain_finish = drain_step && (next_idx >= IDX_W'(TOTAL));
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int k = 0; k < TOTAL; k++) begin
        score_a_q[k] <= '0;
        score_b_q[k] <= '0;
        id_a_q[k]    <= '0;
        id_b_q[k]    <= '0;
      end
      ptr_q <= '0;
    end else begin
      for (int k = 0; k < TOTAL; k++) begin
        if (clear_frame) begin
          score_a_q[k] <= '0;
          score_b_q[k] <= '0;
          id_a_q[k]    <= '0;
          id_b_q[k]    <= '0;
          ptr_q[k]     <= 1'b0;
        end else if (fill_wr_en && wr_addr == IDX_W'(k)) begin
          score_a_q[k] <= sb.pe_score_a;
          score_b_q[k] <= sb.pe_score_b;
          id_a_q[k]    <= sb.pe_id_a;
          id_b_q[k]    <= sb.pe_id_b;
          ptr_q[k]     <= 1'b0;
        end else if (ptr_wr_en && ptr_addr == IDX_W'(k)) begin
          ptr_q[k]     <= sb.data_to_score_board;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_row_q       <= '0;
      start_cr_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      conflict_err_q <= 1'b0;
      drain_idx_q    <= '0;
      out_valid_q    <= 1'b0;
      out_row_q      <= '0;
      out_pe_q       <= '0;
      out_id_q       <= '0;
      out_score_q    <= '0;
    end else begin
      wr_row_q     <= wr_row_d;
      start_cr_q   <= launch_cr;
      frame_done_q <= drain_finish;
      if (clear_frame)      conflict_err_q <= 1'b0;
      else if (enter_drain) conflict_err_q <= conflict_err_q | sb.conflict_counter_th;
      if (enter_drain)     drain_idx_q <= '0;
      else if (drain_load) drain_idx_q <= next_idx + IDX_W'(1);
      if (drain_load) begin
        out_valid_q <= 1'b1;
        out_row_q   <= ld_row;
        out_pe_q    <= ld_pe;
        out_id_q    <= ld_id;
        out_score_q <= ld_score;
      end else if (drain_finish) begin
        out_valid_q <= 1'b0;
        out_row_q   <= '0;
        out_pe_q    <= '0;
        out_id_q    <= '0;
        out_score_q <= '0;
      end
    end
  end

  assign sb.start_cr     = start_cr_q;
  assign sb.score_to_cr  = rd_score;
  assign sb.id_to_cr     = rd_id;
  assign sb.out_valid    = out_valid_q;
  assign sb.out_row      = out_row_q;
  assign sb.out_pe       = out_pe_q;
  assign sb.out_id       = out_id_q;
  assign sb.out_score    = out_score_q;
  assign sb.frame_done   = frame_done_q;
  assign sb.conflict_err = conflict_err_q;
  assign dbg_state_o     = state_q;
endmodule
